// File: rtl/pma_regions.sv
// rtl/pma_regions.sv - programmable PMA region table with registered multi-channel lookup
// Optional lock support: define RIVER_PMA_LOCK_EN.
module pma_regions #(
  parameter int abits    = 48,
  parameter int regions  = 8,
  parameter int channels = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [channels-1:0]       i_req_valid,
  input  logic [channels*abits-1:0] i_req_addr,
  output logic [channels-1:0]       o_resp_valid,
  output logic [channels-1:0]       o_hit,
  output logic [channels*4-1:0]     o_region,
  output logic [channels-1:0]       o_cached,
  output logic [channels-1:0]       o_exec,
  output logic [channels-1:0]       o_wr,
  input  logic                      i_cfg_we,
  input  logic [3:0]                i_cfg_idx,
  input  logic [abits-1:0]          i_cfg_base,
  input  logic [abits-1:0]          i_cfg_mask,
  input  logic [4:0]                i_cfg_attr,
  output logic                      o_cfg_ack,
  output logic                      o_cfg_err
);

  localparam logic [63:0] CLINT_BAR  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINT_MASK = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] PLIC_BAR   = 64'h0000_0000_0C00_0000;
  localparam logic [63:0] PLIC_MASK  = 64'h0000_0000_03FF_FFFF;
  localparam logic [63:0] IO1_BAR    = 64'h0000_0000_1000_0000;
  localparam logic [63:0] IO1_MASK   = 64'h0000_0000_000F_FFFF;

  logic [abits-1:0]   base_q [regions];
  logic [abits-1:0]   mask_q [regions];
  logic [regions-1:0] valid_q, cached_q, exec_q, wr_q;

  logic [channels-1:0]   resp_valid_q, hit_q, cached_q_o, exec_q_o, wr_q_o;
  logic [channels*4-1:0] region_q;
  logic                  cfg_ack_q, cfg_err_q;

  logic [channels-1:0]   hit_d, cached_d, exec_d, wr_d;
  logic [channels*4-1:0] region_d;
  logic                  idx_ok, locked, wr_en;

  assign idx_ok = ({1'b0, i_cfg_idx} < 5'(regions));

`ifdef RIVER_PMA_LOCK_EN
  logic [regions-1:0] lock_q;

  always_comb begin
    locked = 1'b0;
    for (int r = 0; r < regions; r++) begin
      if (i_cfg_idx == 4'(r)) locked = lock_q[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q <= '0;
      lock_q[2:0] <= 3'b111;
    end else if (wr_en) begin
      for (int r = 0; r < regions; r++) begin
        if (i_cfg_idx == 4'(r)) lock_q[r] <= i_cfg_attr[4];
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = i_cfg_attr[4];
  assign locked = 1'b0;
`endif

  assign wr_en = i_cfg_we && idx_ok && !locked;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < regions; r++) begin
        base_q[r] <= '0;
        mask_q[r] <= '0;
      end
      valid_q  <= '0;
      cached_q <= '0;
      exec_q   <= '0;
      wr_q     <= '0;
      base_q[0] <= CLINT_BAR[abits-1:0];
      mask_q[0] <= CLINT_MASK[abits-1:0];
      base_q[1] <= PLIC_BAR[abits-1:0];
      mask_q[1] <= PLIC_MASK[abits-1:0];
      base_q[2] <= IO1_BAR[abits-1:0];
      mask_q[2] <= IO1_MASK[abits-1:0];
      valid_q[2:0] <= 3'b111;
    end else if (wr_en) begin
      for (int r = 0; r < regions; r++) begin
        if (i_cfg_idx == 4'(r)) begin
          base_q[r]   <= i_cfg_base;
          mask_q[r]   <= i_cfg_mask;
          valid_q[r]  <= i_cfg_attr[0];
          cached_q[r] <= i_cfg_attr[1];
          exec_q[r]   <= i_cfg_attr[2];
          wr_q[r]     <= i_cfg_attr[3];
        end
      end
    end
  end

  // Scan from the top so the lowest matching index is the last one to assign.
  always_comb begin
    hit_d    = '0;
    region_d = '0;
    cached_d = '1;
    exec_d   = '1;
    wr_d     = '1;
    for (int k = 0; k < channels; k++) begin
      for (int r = regions - 1; r >= 0; r--) begin
        if (valid_q[r] &&
            ((i_req_addr[k*abits +: abits] & ~mask_q[r]) == (base_q[r] & ~mask_q[r]))) begin
          hit_d[k]          = 1'b1;
          region_d[k*4 +: 4] = 4'(r);
          cached_d[k]       = cached_q[r];
          exec_d[k]         = exec_q[r];
          wr_d[k]           = wr_q[r];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_valid_q <= '0;
      hit_q        <= '0;
      region_q     <= '0;
      cached_q_o   <= '0;
      exec_q_o     <= '0;
      wr_q_o       <= '0;
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      resp_valid_q <= i_req_valid;
      for (int k = 0; k < channels; k++) begin
        if (i_req_valid[k]) begin
          hit_q[k]           <= hit_d[k];
          region_q[k*4 +: 4] <= region_d[k*4 +: 4];
          cached_q_o[k]      <= cached_d[k];
          exec_q_o[k]        <= exec_d[k];
          wr_q_o[k]          <= wr_d[k];
        end
      end
      cfg_ack_q <= wr_en;
      cfg_err_q <= i_cfg_we && !wr_en;
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_hit        = hit_q;
  assign o_region     = region_q;
  assign o_cached     = cached_q_o;
  assign o_exec       = exec_q_o;
  assign o_wr         = wr_q_o;
  assign o_cfg_ack    = cfg_ack_q;
  assign o_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pma_regions.sv
// tb/tb_pma_regions.sv - self-checking bench for pma_regions (honours RIVER_PMA_LOCK_EN)
module tb_pma_regions;

  localparam logic [47:0] CLINT_BAR  = 48'h0000_0200_0000;
  localparam logic [47:0] CLINT_MASK = 48'h0000_0000_FFFF;
  localparam logic [47:0] PLIC_BAR   = 48'h0000_0C00_0000;
  localparam logic [47:0] PLIC_MASK  = 48'h0000_03FF_FFFF;
  localparam logic [47:0] IO1_BAR    = 48'h0000_1000_0000;
  localparam logic [47:0] IO1_MASK   = 48'h0000_000F_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [95:0] req_addr;
  logic [1:0]  resp_valid, hit, cached, exec, wr;
  logic [7:0]  region;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [47:0] cfg_base, cfg_mask;
  logic [4:0]  cfg_attr;
  logic        cfg_ack, cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pma_regions #(.abits(48), .regions(8), .channels(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_resp_valid(resp_valid), .o_hit(hit), .o_region(region),
    .o_cached(cached), .o_exec(exec), .o_wr(wr),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_base(cfg_base),
    .i_cfg_mask(cfg_mask), .i_cfg_attr(cfg_attr),
    .o_cfg_ack(cfg_ack), .o_cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: attr layout {lock, wr, exec, cached, valid}
  logic [47:0] m_base [8];
  logic [47:0] m_mask [8];
  logic [4:0]  m_attr [8];
  logic [1:0]  e_rv, e_hit, e_c, e_x, e_w;
  logic [3:0]  e_reg [2];
  logic        e_ack, e_err;
  bit          armed = 0;

  function automatic int find(input logic [47:0] a);
    for (int r = 0; r < 8; r++)
      if (m_attr[r][0] && ((a | m_mask[r]) == (m_base[r] | m_mask[r]))) return r;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) begin
        m_base[r] = '0; m_mask[r] = '0; m_attr[r] = '0;
      end
      m_base[0] = CLINT_BAR; m_mask[0] = CLINT_MASK;
      m_base[1] = PLIC_BAR;  m_mask[1] = PLIC_MASK;
      m_base[2] = IO1_BAR;   m_mask[2] = IO1_MASK;
`ifdef RIVER_PMA_LOCK_EN
      for (int r = 0; r < 3; r++) m_attr[r] = 5'b10001;
`else
      for (int r = 0; r < 3; r++) m_attr[r] = 5'b00001;
`endif
      e_rv = 0; e_hit = 0; e_c = 0; e_x = 0; e_w = 0;
      e_reg[0] = 0; e_reg[1] = 0; e_ack = 0; e_err = 0;
      armed = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (req_valid[k]) begin
          int m;
          m = find(req_addr[k*48 +: 48]);
          if (m < 0) begin
            e_hit[k] = 0; e_reg[k] = 0; e_c[k] = 1; e_x[k] = 1; e_w[k] = 1;
          end else begin
            e_hit[k] = 1; e_reg[k] = 4'(m);
            e_c[k] = m_attr[m][1]; e_x[k] = m_attr[m][2]; e_w[k] = m_attr[m][3];
          end
        end
      end
      e_rv = req_valid;
      e_ack = 0; e_err = 0;
      if (cfg_we) begin
        if (cfg_idx >= 8 || m_attr[cfg_idx[2:0]][4]) e_err = 1;
        else begin
          m_base[cfg_idx[2:0]] = cfg_base;
          m_mask[cfg_idx[2:0]] = cfg_mask;
`ifdef RIVER_PMA_LOCK_EN
          m_attr[cfg_idx[2:0]] = cfg_attr;
`else
          m_attr[cfg_idx[2:0]] = {1'b0, cfg_attr[3:0]};
`endif
          e_ack = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("resp_valid%0d", k), 64'(resp_valid[k]), 64'(e_rv[k]));
        check($sformatf("hit%0d", k), 64'(hit[k]), 64'(e_hit[k]));
        check($sformatf("region%0d", k), 64'(region[k*4 +: 4]), 64'(e_reg[k]));
        check($sformatf("cached%0d", k), 64'(cached[k]), 64'(e_c[k]));
        check($sformatf("exec%0d", k), 64'(exec[k]), 64'(e_x[k]));
        check($sformatf("wr%0d", k), 64'(wr[k]), 64'(e_w[k]));
      end
      check("cfg_ack", 64'(cfg_ack), 64'(e_ack));
      check("cfg_err", 64'(cfg_err), 64'(e_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    req_valid = 0;
    cfg_we = 0;
  endtask

  task automatic set_req(input int ch, input logic [47:0] a);
    req_valid[ch] = 1'b1;
    req_addr[ch*48 +: 48] = a;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [47:0] b, input logic [47:0] m,
                     input logic [4:0] at);
    cfg_we = 1; cfg_idx = idx; cfg_base = b; cfg_mask = m; cfg_attr = at;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_addr = '0; cfg_we = 0;
    cfg_idx = 0; cfg_base = 0; cfg_mask = 0; cfg_attr = 0;
    cyc(); cyc();
    rst = 0;
    check("lit_reset_rv", 64'(resp_valid), 64'd0);
    check("lit_reset_cached", 64'(cached), 64'd0);

    set_req(1, CLINT_BAR + 48'h10); cyc();
    check("lit_clint_rv", 64'(resp_valid[1]), 64'd1);
    check("lit_clint_hit", 64'(hit[1]), 64'd1);
    check("lit_clint_region", 64'(region[7:4]), 64'd0);
    check("lit_clint_cached", 64'(cached[1]), 64'd0);
    clear();

    set_req(0, 48'h0000_8000_0000); cyc();
    check("lit_miss_hit", 64'(hit[0]), 64'd0);
    check("lit_miss_attr", 64'({cached[0], exec[0], wr[0]}), 64'h7);
    clear();

    cfg(3, 48'h8000_0000, 48'hFFFF, 5'b00101); cyc();
    check("lit_wr3_ack", 64'({cfg_ack, cfg_err}), 64'h2);
    cfg(5, 48'h8000_0000, 48'hF_FFFF, 5'b01111); cyc();
    check("lit_wr5_ack", 64'(cfg_ack), 64'd1);
    clear();

    set_req(0, 48'h8000_1000); set_req(1, 48'h8008_0000); cyc();
    check("lit_ovl_region3", 64'(region[3:0]), 64'd3);
    check("lit_ovl_attr3", 64'({cached[0], exec[0], wr[0]}), 64'h2);
    check("lit_ovl_region5", 64'(region[7:4]), 64'd5);
    check("lit_ovl_cached5", 64'(cached[1]), 64'd1);
    clear();

    cfg(3, 48'h8000_0000, 48'hFFFF, 5'b00000); set_req(0, 48'h8000_1000); cyc();
    check("lit_same_cycle_region", 64'(region[3:0]), 64'd3);
    clear();
    set_req(0, 48'h8000_1000); cyc();
    check("lit_after_write_region", 64'(region[3:0]), 64'd5);
    check("lit_after_write_wr", 64'(wr[0]), 64'd1);
    clear();

    cfg(9, 48'h0, 48'hFFFF_FFFF_FFFF, 5'b00001); cyc();
    check("lit_oor_err", 64'({cfg_ack, cfg_err}), 64'h1);
    clear();
    set_req(1, 48'h1234_0000_0000); cyc();
    check("lit_oor_unchanged", 64'(hit[1]), 64'd0);
    clear();

    set_req(0, PLIC_BAR + 48'h100); cyc();
    check("lit_plic_region", 64'(region[3:0]), 64'd1);
    clear(); cyc();
    check("lit_idle_rv", 64'(resp_valid), 64'd0);
    check("lit_idle_hold", 64'(region[3:0]), 64'd1);

    cfg(1, PLIC_BAR, PLIC_MASK, 5'b00011); cyc();
`ifdef RIVER_PMA_LOCK_EN
    check("lit_locked_err", 64'(cfg_err), 64'd1);
`else
    check("lit_unlocked_ack", 64'(cfg_ack), 64'd1);
`endif
    clear();
    set_req(0, PLIC_BAR + 48'h4); cyc();
`ifdef RIVER_PMA_LOCK_EN
    check("lit_plic_still_uncached", 64'(cached[0]), 64'd0);
`else
    check("lit_plic_now_cached", 64'(cached[0]), 64'd1);
`endif
    clear();

    cfg(7, 48'h0, 48'hFFFF_FFFF_FFFF, 5'b00011); cyc();
    clear();
    set_req(1, 48'hFFFF_0000_0000); cyc();
    check("lit_allones_region", 64'(region[7:4]), 64'd7);
    clear();

    set_req(0, CLINT_BAR); rst = 1; cyc();
    check("lit_rst_drop_rv", 64'(resp_valid), 64'd0);
    rst = 0; clear();
    cfg(3, 48'h9000_0000, 48'hFF, 5'b00001); cyc();
    check("lit_post_rst_ack", 64'(cfg_ack), 64'd1);
    clear();
    set_req(0, 48'h9000_0010); set_req(1, 48'hFFFF_0000_0000); cyc();
    check("lit_post_rst_region3", 64'(region[3:0]), 64'd3);
    check("lit_post_rst_entry7_clear", 64'(hit[1]), 64'd0);
    clear();
`ifdef RIVER_PMA_LOCK_EN
    cfg(1, PLIC_BAR, PLIC_MASK, 5'b00001); cyc();
    check("lit_relocked_err", 64'(cfg_err), 64'd1);
    clear();
`endif
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
